// File: rtl/oled_bus_arbiter_if.sv
// ============================================================================
// Module   : oled_bus_arbiter_if
// Brief    : Requester and OLED bus signals shared by the OLED bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface oled_bus_arbiter_if;
    logic req0;
    logic req1;
    logic done0;
    logic done1;
    logic scl0;
    logic scl1;
    logic sda_o0;
    logic sda_oe0;
    logic sda_o1;
    logic sda_oe1;
    logic gnt0;
    logic gnt1;
    logic OLED_SCL;
    logic OLED_SDA_O;
    logic OLED_SDA_OE;
    logic busy;
    logic timeout_err;

    // Requester side: drives requests and its own SCL/SDA, observes the grants.
    modport master (
        output req0, req1, done0, done1,
        output scl0, scl1, sda_o0, sda_oe0, sda_o1, sda_oe1,
        input  gnt0, gnt1, OLED_SCL, OLED_SDA_O, OLED_SDA_OE, busy, timeout_err
    );

    modport slave (
        input  req0, req1, done0, done1,
        input  scl0, scl1, sda_o0, sda_oe0, sda_o1, sda_oe1,
        output gnt0, gnt1, OLED_SCL, OLED_SDA_O, OLED_SDA_OE, busy, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/oled_bus_arbiter.sv
// ============================================================================
// Module   : oled_bus_arbiter
// Brief    : Two-requester OLED I2C bus arbiter with fair tie-break, a guard
//            gap after every grant, and an optional grant watchdog enabled by
//            the macro OLED_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  wire logic         CLOCK,
    input  wire logic         RST,
    oled_bus_arbiter_if.slave bus
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_GNT0       = 2'd1;
    localparam logic [1:0]  c_GNT1       = 2'd2;
    localparam logic [1:0]  c_GUARD      = 2'd3;
    localparam logic [15:0] c_GUARD_LAST = 16'(GUARD_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_last1;      // 1 when requester 1 was served most recently
    logic [15:0] r_guard_cnt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        w_end;
    logic        w_expire;
    logic        w_in_grant;

    assign w_in_grant = (r_state == c_GNT0) || (r_state == c_GNT1);

`ifdef OLED_ARB_TIMEOUT_EN
    localparam logic [23:0] c_TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] r_to_cnt;
    logic        r_timeout_err;

    // A normal end on the expiry edge wins over the watchdog.
    assign w_expire = w_in_grant && !w_end && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_to_cnt      <= 24'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_expire;
            if (w_in_grant && (w_next == r_state))
                r_to_cnt <= r_to_cnt + 24'd1;
            else
                r_to_cnt <= 24'd0;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_expire         = 1'b0;
    assign bus.timeout_err  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_end  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.req0 && bus.req1)
                    w_next = r_last1 ? c_GNT0 : c_GNT1;
                else if (bus.req0)
                    w_next = c_GNT0;
                else if (bus.req1)
                    w_next = c_GNT1;
            end
            c_GNT0:  w_end = bus.done0 || !bus.req0;
            c_GNT1:  w_end = bus.done1 || !bus.req1;
            c_GUARD: begin
                if (r_guard_cnt == c_GUARD_LAST)
                    w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
        if (w_end || w_expire)
            w_next = c_GUARD;
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_last1     <= 1'b1;
            r_guard_cnt <= 16'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == c_GNT0);
            r_gnt1  <= (w_next == c_GNT1);
            if ((r_state == c_IDLE) && (w_next == c_GNT0))
                r_last1 <= 1'b0;
            else if ((r_state == c_IDLE) && (w_next == c_GNT1))
                r_last1 <= 1'b1;
            if ((r_state == c_GUARD) && (w_next == c_GUARD))
                r_guard_cnt <= r_guard_cnt + 16'd1;
            else
                r_guard_cnt <= 16'd0;
        end
    end

    // Bus is parked released (SCL high, SDA not driven) outside a grant.
    always_comb begin
        bus.OLED_SCL    = 1'b1;
        bus.OLED_SDA_O  = 1'b1;
        bus.OLED_SDA_OE = 1'b0;
        case (r_state)
            c_GNT0: begin
                bus.OLED_SCL    = bus.scl0;
                bus.OLED_SDA_O  = bus.sda_o0;
                bus.OLED_SDA_OE = bus.sda_oe0;
            end
            c_GNT1: begin
                bus.OLED_SCL    = bus.scl1;
                bus.OLED_SDA_O  = bus.sda_o1;
                bus.OLED_SDA_OE = bus.sda_oe1;
            end
            default: ;
        endcase
    end

    assign bus.gnt0 = r_gnt0;
    assign bus.gnt1 = r_gnt1;
    assign bus.busy = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_oled_bus_arbiter.sv
// ============================================================================
// Module   : tb_oled_bus_arbiter
// Brief    : Self-checking bench for oled_bus_arbiter against a behavioural
//            ownership/guard model; honours OLED_ARB_TIMEOUT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oled_bus_arbiter;

    localparam int GUARD = 50;
    localparam int TO    = 100;
`ifdef OLED_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLOCK = 1'b0;
    logic RST   = 1'b1;

    oled_bus_arbiter_if bus ();

    oled_bus_arbiter #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK (CLOCK),
        .RST   (RST),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus (-1 none), guard cycles still to run, grant age.
    int m_owner      = -1;
    int m_guard_left = 0;
    int m_age        = 0;
    bit m_last1      = 1'b1;
    bit m_err        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit fin;
        bit expired;
        m_err = 1'b0;
        if (RST) begin
            m_owner      = -1;
            m_guard_left = 0;
            m_age        = 0;
            m_last1      = 1'b1;
        end else if (m_owner >= 0) begin
            fin     = (m_owner == 0) ? (bus.done0 || !bus.req0) : (bus.done1 || !bus.req1);
            expired = TO_EN && !fin && (m_age == TO);
            if (fin || expired) begin
                m_owner      = -1;
                m_guard_left = GUARD;
                m_err        = expired;
            end else begin
                m_age++;
            end
        end else if (m_guard_left > 0) begin
            m_guard_left--;
        end else if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1)
                m_owner = m_last1 ? 0 : 1;
            else
                m_owner = bus.req0 ? 0 : 1;
            m_last1 = (m_owner == 1);
            m_age   = 1;
        end
    endtask

    task automatic compare();
        logic exp_scl, exp_sda, exp_oe;
        exp_scl = 1'b1;
        exp_sda = 1'b1;
        exp_oe  = 1'b0;
        if (m_owner == 0) begin
            exp_scl = bus.scl0; exp_sda = bus.sda_o0; exp_oe = bus.sda_oe0;
        end else if (m_owner == 1) begin
            exp_scl = bus.scl1; exp_sda = bus.sda_o1; exp_oe = bus.sda_oe1;
        end
        check("gnt0",        bus.gnt0,        32'(m_owner == 0));
        check("gnt1",        bus.gnt1,        32'(m_owner == 1));
        check("busy",        bus.busy,        32'((m_owner >= 0) || (m_guard_left > 0)));
        check("timeout_err", bus.timeout_err, 32'(m_err));
        check("OLED_SCL",    bus.OLED_SCL,    32'(exp_scl));
        check("OLED_SDA_O",  bus.OLED_SDA_O,  32'(exp_sda));
        check("OLED_SDA_OE", bus.OLED_SDA_OE, 32'(exp_oe));
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_update();
        @(negedge CLOCK);
        compare();
    endtask

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.done0 = 0; bus.done1 = 0;
        bus.scl0 = 1; bus.scl1 = 1; bus.sda_o0 = 1; bus.sda_oe0 = 0;
        bus.sda_o1 = 1; bus.sda_oe1 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "bench time limit");
    end

    initial begin
        int cnt;
        int pulses;
        clear_inputs();
        do_reset();

        // Reset state
        step();
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_scl",  bus.OLED_SCL, 1);
        check("rst_oe",   bus.OLED_SDA_OE, 0);

        // Single grant to requester 0, mux follow, guard length
        bus.req0 = 1;
        step();
        check("lat_gnt0", bus.gnt0, 1);
        bus.scl0 = 0; bus.sda_oe0 = 1; bus.sda_o0 = 0;
        #1;
        check("scl_follow", bus.OLED_SCL, 0);
        check("oe_follow",  bus.OLED_SDA_OE, 1);
        bus.done0 = 1; bus.req0 = 0;
        step();
        bus.done0 = 0;
        check("done_gnt0", bus.gnt0, 0);
        check("done_busy", bus.busy, 1);
        cnt = 1;
        while (bus.busy && cnt < 200) begin
            step();
            if (bus.busy) begin
                cnt++;
                check("guard_oe", bus.OLED_SDA_OE, 0);
            end
        end
        check("guard_len", cnt, GUARD);

        // Simultaneous requests alternate fairly
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        step();
        check("tie_first_gnt0", bus.gnt0, 1);
        bus.done0 = 1; bus.req0 = 0;
        step();
        bus.done0 = 0;
        cnt = 1;
        while (!bus.gnt1 && cnt < 200) begin
            step();
            if (!bus.gnt1) cnt++;
        end
        check("gap_to_gnt1", cnt, GUARD + 1);
        check("tie_then_gnt1", bus.gnt1, 1);
        bus.done1 = 1; bus.req1 = 0;
        step();
        bus.done1 = 0;
        cnt = 0;
        while (bus.busy && cnt < 200) begin step(); cnt++; end
        bus.req0 = 1; bus.req1 = 1;
        step();
        check("tie_back_gnt0", bus.gnt0, 1);
        clear_inputs();

        // Reset in the middle of a grant releases the bus at once
        do_reset();
        bus.req1 = 1; bus.sda_oe1 = 1; bus.scl1 = 0;
        repeat (3) step();
        RST = 1'b1;
        step();
        check("midrst_gnt1", bus.gnt1, 0);
        check("midrst_oe",   bus.OLED_SDA_OE, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_err",  bus.timeout_err, 0);
        RST = 1'b0;
        clear_inputs();

        // Held request with no done: watchdog expiry, or indefinite grant
        do_reset();
        bus.req1 = 1;
        cnt = 0; pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (bus.gnt1) cnt++;
            if (bus.timeout_err) pulses++;
            if (TO_EN && !bus.gnt1 && cnt > 0) break;
        end
        check("hold_len",    cnt,    TO_EN ? TO : 10000);
        check("hold_pulses", pulses, TO_EN ? 1 : 0);
        clear_inputs();

        // done on the expiry cycle is a normal end
        do_reset();
        bus.req1 = 1;
        step();
        repeat (TO - 1) step();
        bus.done1 = 1;
        step();
        bus.done1 = 0;
        check("done_at_expiry_err",  bus.timeout_err, 0);
        check("done_at_expiry_gnt1", bus.gnt1, 0);
        clear_inputs();

        // Randomised traffic with occasional resets
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 15) == 0) bus.req1 = ~bus.req1;
            bus.done0   = ($urandom_range(0, 29) == 0);
            bus.done1   = ($urandom_range(0, 29) == 0);
            bus.scl0    = 1'($urandom);
            bus.scl1    = 1'($urandom);
            bus.sda_o0  = 1'($urandom);
            bus.sda_oe0 = 1'($urandom);
            bus.sda_o1  = 1'($urandom);
            bus.sda_oe1 = 1'($urandom);
            RST         = ($urandom_range(0, 999) == 0);
            step();
        end
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oled_bus_arbiter.md
OLED_BUS_ARBITER -- requirements
Module: oled_bus_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 50: bus-free cycles inserted after every grant ends; legal range 1..65535.
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: maximum grant length in cycles; legal range 2..2^24-1.
REQ-003 CLOCK  in  1  single system clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 req0, req1  in  1 each  bus requests; req0 is the init engine, req1 is the write engine.
REQ-006 done0, done1  in  1 each  single-cycle end-of-transaction pulses from the requesters.
REQ-007 scl0, scl1  in  1 each  requester SCL drive.
REQ-008 sda_o0, sda_oe0, sda_o1, sda_oe1  in  1 each  requester SDA data and output-enable.
REQ-009 gnt0, gnt1  out  1 each  registered grants; gnt0 and gnt1 are one-hot or zero.
REQ-010 OLED_SCL  out  1  muxed bus clock.
REQ-011 OLED_SDA_O, OLED_SDA_OE  out  1 each  muxed SDA data and enable; the top level builds the inout from these.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse on a forced grant revoke.

Function
REQ-014 FSM states are IDLE, GNT0, GNT1 and GUARD, held in a state register.
REQ-015 IDLE transitions: only req0 -> GNT0; only req1 -> GNT1; both -> the requester not served last; neither -> stay in IDLE.
REQ-016 The last-served flag is reset to 1, so req0 wins the first simultaneous request.
REQ-017 Grant latency: req high in IDLE at edge N -> gnt high after edge N+1.
REQ-018 GNTx exits to GUARD on donex or on reqx low; gntx is low after that edge.
REQ-019 GUARD lasts exactly GUARD_CYCLES cycles, counter 16-bit, then goes to IDLE; requests are ignored during GUARD.
REQ-020 Output mux is combinational from the registered state.
REQ-021 In GNT0, OLED_SCL/SDA_O/SDA_OE = scl0/sda_o0/sda_oe0; in GNT1 they = scl1/sda_o1/sda_oe1.
REQ-022 In IDLE and GUARD, OLED_SCL=1, OLED_SDA_O=1 and OLED_SDA_OE=0; the outputs are never X.
REQ-023 done of the non-granted requester is ignored.
REQ-024 Requester holding reqx high through GUARD is re-arbitrated in IDLE under the REQ-015 rules.
REQ-025 No request is queued or remembered across a grant.

Reset
REQ-026 While RST=1 at an edge: state=IDLE, gnt0=gnt1=0, busy=0, timeout_err=0, counters=0, last-served=1.
REQ-027 Reset mid-grant drops the grant at that edge with no GUARD period; the bus is released immediately per REQ-022.

Configuration
REQ-028 Macro OLED_ARB_TIMEOUT_EN controls the grant watchdog.
REQ-029 With OLED_ARB_TIMEOUT_EN defined, a 24-bit counter clears on grant entry and increments each GNT cycle.
REQ-030 With OLED_ARB_TIMEOUT_EN defined, the counter at TIMEOUT_CYCLES-1 with no done forces GUARD and pulses timeout_err for one cycle.
REQ-031 With OLED_ARB_TIMEOUT_EN defined, done at the same edge as expiry counts as a normal end with no timeout_err.
REQ-032 Without OLED_ARB_TIMEOUT_EN, no watchdog counter exists, timeout_err is tied 0, and a grant lasts until done or req drops.

Verification
REQ-033 Reset release, req0=1 one cycle later -> gnt0=1 one edge after; OLED_SCL follows scl0; done0 pulse -> gnt0=0, busy=1 for 50 cycles, then IDLE.
REQ-034 req0=req1=1 together from reset -> gnt0 first; after done0 and 50 guard cycles -> gnt1; next simultaneous request -> gnt0.
REQ-035 req1 asserted during GNT0 -> gnt1 only after GUARD completes; OLED_SDA_OE=0 and OLED_SCL=1 for every guard cycle.
REQ-036 RST=1 mid-GNT1 -> gnt1=0, OLED_SDA_OE=0 and busy=0 after that edge; no timeout_err.
REQ-037 With OLED_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold req1 with no done1 -> timeout_err pulses once at grant cycle 100, gnt1 drops, GUARD entered.
REQ-038 With OLED_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, done1 on cycle 100 -> no timeout_err.
REQ-039 Without OLED_ARB_TIMEOUT_EN, the same stimulus as REQ-037 -> grant held 10000 cycles, timeout_err stays 0.
